qadd_rr_sched: RTL and testbench
================================

Name: qadd_rr_sched

Overview:
- Round-robin scheduler that shares one `qadd` instance (signed-magnitude fixed point, QN format, 1-cycle latency, `i_start`/`add_res_vld` handshake) between NREQ requesters.
- Accepts one operand pair per grant and sequences the adder.
- Returns the tagged result with a valid/ready output handshake and an overflow flag.
- Sits between the error-estimation accumulators and the single shared adder.

Parameters:
- N, 32, total word width; bit N-1 is the sign, bits N-2:0 are the magnitude.
- Q, 23, fractional bits; passed through to `qadd` only.
- NREQ, 4, number of requesters (2..16).
- IDW, $clog2(NREQ), requester-id width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request; held high until that requester's gnt.
- addend_bus  in  NREQ*N  requester i operand A at [i*N +: N]; stable while req[i] is high.
- adder_bus  in  NREQ*N  requester i operand B, same slicing.
- gnt  out  NREQ  registered one-hot pulse, 1 cycle; operands were captured on the preceding edge.
- res_data  out  N  sum in signed-magnitude form.
- res_id  out  IDW  index of the requester that owns res_data.
- res_ovf  out  1  magnitude overflow (wrapped result).
- res_vld  out  1  result valid.
- res_rdy  in  1  consumer accepts the result when res_vld && res_rdy.
- busy  out  1  high whenever the FSM state is not IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; gnt, res_data, res_id, res_ovf, res_vld = 0.
  - Round-robin pointer ptr = NREQ-1, so requester 0 wins first.
  - Operand registers cleared.
- `qadd` reset: its synchronous active-high rst is driven by ~rst.
- FSM states:
  - IDLE: if |req, choose the first set bit searching ptr+1, ptr+2, … modulo NREQ. On that edge:
    - gnt <= onehot(winner); ptr <= winner; cur_id <= winner.
    - Latch a_q/b_q from the winner's slices.
    - Go to ISSUE.
    - If no req, stay in IDLE.
  - ISSUE: i_start=1 for exactly this cycle (decoded from state); gnt returns to 0; next state WAIT.
  - WAIT: on add_res_vld, load res_data <= add_res, res_id <= cur_id, res_ovf <= ovf_q; go to OUT. Otherwise hold (not reachable with a 1-cycle adder).
  - OUT: res_vld=1; res_data/res_id/res_ovf held stable. On res_rdy, go to IDLE. No new grant is issued while in OUT.
- Timing:
  - Latency: req sampled in IDLE at edge 0 → res_vld high in the cycle after edge 2 (3 cycles).
  - Throughput: one operation per 4 cycles with res_rdy tied high.
- Arithmetic:
  - Result is exactly `qadd` semantics; equal magnitudes with opposite signs give +0 (sign bit 0).
  - ovf_q is computed at grant: ovf_q = (a_q[N-1]==b_q[N-1]) && carry out of a_q[N-2:0]+b_q[N-2:0] into bit N-1.
  - No saturation; the magnitude wraps mod 2^(N-1).
- Boundary conditions:
  - A req that drops before being granted is simply not served.
  - A requester must not reassert req in the cycle gnt is seen; one grant per req assertion.
  - Simultaneous reqs are served strictly by the round-robin order above; a lone requester is granted repeatedly.
  - Reset asserted mid-operation (any state) aborts immediately. The in-flight result is discarded with no res_vld, and ptr returns to NREQ-1.
  - res_rdy high outside OUT is ignored.

Decomposition:
- Shared package:
  - State encoding (IDLE, ISSUE, WAIT, OUT as a 2-bit localparam set).
  - Default N/Q.
  - Fixed-point constant ONE = 1<<Q.
- Sub-modules:
  - `qadd` (existing) is instantiated once.
  - rr_pick is a natural combinational sub-module: inputs req and ptr, outputs winner index and a found flag.

Test Plan:
- req=4'b0001, A=0x00C00000 (1.5), B=0x80400000 (-0.5), res_rdy=1 → gnt=0001 one cycle after req, res_vld 3 cycles after req, res_data=0x00800000, res_id=0, res_ovf=0.
- Equal magnitudes: A=0x00800000, B=0x80800000 → res_data=0x00000000 (positive zero), res_ovf=0.
- Overflow: A=0x7FFFFFFF, B=0x00000001 → res_data=0x00000000, res_ovf=1; A=0xFFFFFFFF, B=0x80000001 → res_data=0x80000000, res_ovf=1.
- Round-robin: req=4'b1111 held and re-raised after each grant → grant order 0,1,2,3,0; then req=4'b1010 after a grant to 1 → next grant 3.
- Backpressure: res_rdy=0 for 5 cycles in OUT with req=4'b0110 pending → res_vld and res_data held stable, gnt stays 0, busy=1; res_rdy=1 → IDLE, next grant issued the following cycle.
- Reset mid-op: rst=0 during WAIT → gnt/res_vld/busy=0 immediately; after release, req=4'b1000 → served correctly as id 3 with ptr restarted (req=4'b1001 grants 0 first).

Source files
------------

// File: rtl/qadd_rr_sched_pkg.sv
// Shared definitions for the round-robin adder scheduler.
//   - default word / fraction widths of the fixed-point format
//   - fixed-point constant ONE
//   - scheduler FSM state encoding
package qadd_rr_sched_pkg;

    localparam int N_DEF = 32;
    localparam int Q_DEF = 23;

    localparam logic [N_DEF-1:0] ONE = N_DEF'(1) << Q_DEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

endpackage

// File: rtl/qadd.sv
// Signed-magnitude fixed-point adder with a one-cycle registered result.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   a, b            operands (bit N-1 sign, N-2:0 magnitude)
//   i_start         launch an add with the current operands
//   add_res         registered sum, magnitude wraps mod 2^(N-1)
//   add_res_vld     one-cycle pulse, the cycle after i_start
// Equal magnitudes with opposite signs give +0.
module qadd #(
    parameter int N = 32,
    parameter int Q = 23
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         i_start,
    output logic [N-1:0] add_res,
    output logic         add_res_vld
);

    logic [N-1:0] sum_d;
    logic [N-1:0] res_q;
    logic         vld_q;

    always_comb begin
        sum_d = '0;
        if (a[N-1] == b[N-1]) begin
            sum_d = {a[N-1], a[N-2:0] + b[N-2:0]};
        end else if (a[N-2:0] > b[N-2:0]) begin
            sum_d = {a[N-1], a[N-2:0] - b[N-2:0]};
        end else if (b[N-2:0] > a[N-2:0]) begin
            sum_d = {b[N-1], b[N-2:0] - a[N-2:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= i_start;
            if (i_start) begin
                res_q <= sum_d;
            end
        end
    end

    assign add_res     = res_q;
    assign add_res_vld = vld_q;

endmodule

// File: rtl/qadd_rr_sched_rr_pick.sv
// Round-robin picker: first set request searching ptr+1, ptr+2, ... mod NREQ.
// Ports:
//   req_i     request vector
//   ptr_i     index of the most recent winner
//   winner_o  index of the chosen requester (0 when none)
//   found_o   at least one request is set
module qadd_rr_sched_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [IDW-1:0]  winner_o,
    output logic            found_o
);

    logic [IDW-1:0] idx;

    always_comb begin
        winner_o = '0;
        found_o  = 1'b0;
        idx      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(ptr_i) + k) % NREQ);
            if (!found_o && req_i[idx]) begin
                found_o  = 1'b1;
                winner_o = idx;
            end
        end
    end

endmodule

// File: rtl/qadd_rr_sched.sv
// Round-robin scheduler sharing one qadd between NREQ requesters.
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   req                    per-requester request, held until its gnt
//   addend_bus, adder_bus  operand A / B of requester i at [i*N +: N]
//   gnt                    registered one-hot grant pulse
//   res_data/id/ovf/vld    tagged result, held while res_vld && !res_rdy
//   res_rdy                consumer accepts the result
//   busy                   scheduler not idle
//
// state    | meaning
// ST_IDLE  | waiting for a request; grants and captures operands
// ST_ISSUE | i_start to the adder for exactly one cycle
// ST_WAIT  | waiting for add_res_vld, then loads the result
// ST_OUT   | res_vld high until res_rdy
module qadd_rr_sched
    import qadd_rr_sched_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int Q    = Q_DEF,
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] addend_bus,
    input  logic [NREQ*N-1:0] adder_bus,
    output logic [NREQ-1:0]   gnt,
    output logic [N-1:0]      res_data,
    output logic [IDW-1:0]    res_id,
    output logic              res_ovf,
    output logic              res_vld,
    input  logic              res_rdy,
    output logic              busy
);

    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q, cur_id_q, winner;
    logic            found;
    logic [N-1:0]    a_q, b_q, a_win, b_win;
    logic            ovf_q, ovf_win;
    logic [NREQ-1:0] gnt_q;
    logic [N-1:0]    res_data_q;
    logic [IDW-1:0]  res_id_q;
    logic            res_ovf_q;
    logic            grant, load_res;
    logic [N-1:0]    add_res;
    logic            add_res_vld;

    qadd_rr_sched_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .winner_o (winner),
        .found_o  (found)
    );

    always_comb begin
        a_win = addend_bus[int'(winner)*N +: N];
        b_win = adder_bus[int'(winner)*N +: N];
    end

    // Magnitude carry: a + b >= 2^(N-1) exactly when a > ~b (N-1 bits).
    assign ovf_win = (a_win[N-1] == b_win[N-1]) && (a_win[N-2:0] > ~b_win[N-2:0]);

    always_comb begin
        state_d  = state_q;
        grant    = 1'b0;
        load_res = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant   = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (add_res_vld) begin
                    load_res = 1'b1;
                    state_d  = ST_OUT;
                end
            end
            ST_OUT: begin
                if (res_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q      <= IDW'(NREQ - 1);
            cur_id_q   <= '0;
            a_q        <= '0;
            b_q        <= '0;
            ovf_q      <= 1'b0;
            gnt_q      <= '0;
            res_data_q <= '0;
            res_id_q   <= '0;
            res_ovf_q  <= 1'b0;
        end else begin
            gnt_q <= grant ? (NREQ'(1) << winner) : '0;
            if (grant) begin
                ptr_q    <= winner;
                cur_id_q <= winner;
                a_q      <= a_win;
                b_q      <= b_win;
                ovf_q    <= ovf_win;
            end
            if (load_res) begin
                res_data_q <= add_res;
                res_id_q   <= cur_id_q;
                res_ovf_q  <= ovf_q;
            end
        end
    end

    qadd #(
        .N (N),
        .Q (Q)
    ) u_qadd (
        .clk         (clk),
        .rst         (~rst),
        .a           (a_q),
        .b           (b_q),
        .i_start     (state_q == ST_ISSUE),
        .add_res     (add_res),
        .add_res_vld (add_res_vld)
    );

    assign gnt      = gnt_q;
    assign res_data = res_data_q;
    assign res_id   = res_id_q;
    assign res_ovf  = res_ovf_q;
    assign res_vld  = (state_q == ST_OUT);
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_qadd_rr_sched.sv
module tb_qadd_rr_sched;
    import qadd_rr_sched_pkg::*;

    localparam int N    = 32;
    localparam int Q    = 23;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*N-1:0] abus = '0;
    logic [NREQ*N-1:0] bbus = '0;
    logic              res_rdy = 1'b1;
    logic [NREQ-1:0]   gnt;
    logic [N-1:0]      res_data;
    logic [IDW-1:0]    res_id;
    logic              res_ovf;
    logic              res_vld;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    // Transaction-level model: phase = cycles since grant (0 = idle).
    int              m_phase = 0;
    int              m_ptr   = NREQ - 1;
    int              m_id    = 0;
    logic [NREQ-1:0] m_gnt   = '0;
    logic [N-1:0]    m_data  = '0;
    logic            m_ovf   = 1'b0;

    qadd_rr_sched #(.N(N), .Q(Q), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .addend_bus (abus),
        .adder_bus  (bbus),
        .gnt        (gnt),
        .res_data   (res_data),
        .res_id     (res_id),
        .res_ovf    (res_ovf),
        .res_vld    (res_vld),
        .res_rdy    (res_rdy),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Returns {ovf, sign, magnitude} from signed-magnitude arithmetic.
    function automatic logic [N:0] ref_add(input logic [N-1:0] a, input logic [N-1:0] b);
        longint lim, ma, mb, s;
        logic   sg, ov;
        lim = longint'(1) << (N - 1);
        ma  = longint'(a[N-2:0]);
        mb  = longint'(b[N-2:0]);
        ov  = 1'b0;
        sg  = 1'b0;
        s   = 0;
        if (a[N-1] == b[N-1]) begin
            s  = ma + mb;
            ov = (s >= lim);
            s  = s % lim;
            sg = a[N-1];
        end else if (ma > mb) begin
            s  = ma - mb;
            sg = a[N-1];
        end else if (mb > ma) begin
            s  = mb - ma;
            sg = b[N-1];
        end
        return {ov, sg, s[N-2:0]};
    endfunction

    task automatic model_step();
        logic [N:0] r;
        if (!rst) begin
            m_phase = 0;
            m_ptr   = NREQ - 1;
            m_gnt   = '0;
        end else begin
            m_gnt = '0;
            case (m_phase)
                0: begin
                    for (int k = 1; k <= NREQ; k++) begin
                        automatic int w = (m_ptr + k) % NREQ;
                        if (m_phase == 0 && req[w]) begin
                            r        = ref_add(abus[w*N +: N], bbus[w*N +: N]);
                            m_ptr    = w;
                            m_id     = w;
                            m_gnt[w] = 1'b1;
                            m_data   = r[N-1:0];
                            m_ovf    = r[N];
                            m_phase  = 1;
                        end
                    end
                end
                1: m_phase = 2;
                2: m_phase = 3;
                default: if (res_rdy) m_phase = 0;
            endcase
        end
    endtask

    // One clock: model follows the edge, outputs compared at the falling edge,
    // and a requester drops req once it sees its grant.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (!rst) begin
            chk("rst_gnt", gnt, 0);
            chk("rst_vld", res_vld, 0);
            chk("rst_busy", busy, 0);
        end else begin
            chk("gnt", gnt, m_gnt);
            chk("busy", busy, m_phase != 0);
            chk("res_vld", res_vld, m_phase == 3);
            if (m_phase == 3) begin
                chk("res_data", res_data, m_data);
                chk("res_id", res_id, m_id);
                chk("res_ovf", res_ovf, m_ovf);
            end
        end
        req = req & ~gnt;
    endtask

    task automatic set_req(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        abus[i*N +: N] = a;
        bbus[i*N +: N] = b;
        req[i]         = 1'b1;
    endtask

    function automatic logic [N-1:0] rnd_word();
        logic [N-1:0] v;
        v = $urandom;
        case ($urandom_range(3))
            0: v[N-2:4] = '1;
            1: v[N-2:8] = '0;
            default: ;
        endcase
        return v;
    endfunction

    task automatic set_rand(input int i);
        logic [N-1:0] a, b;
        a = rnd_word();
        b = rnd_word();
        if ($urandom_range(5) == 0) b = {~a[N-1], a[N-2:0]};
        set_req(i, a, b);
    endtask

    task automatic wait_gnt(input string nm, output int w);
        w = -1;
        for (int k = 0; k < 12 && w < 0; k++) begin
            tick();
            for (int i = 0; i < NREQ; i++) if (gnt[i]) w = i;
        end
        if (w < 0) chk({nm, "_timeout"}, 0, 1);
    endtask

    task automatic wait_vld(input string nm);
        int k;
        k = 0;
        while (!res_vld && k < 12) begin
            tick();
            k++;
        end
        if (!res_vld) chk({nm, "_timeout"}, 0, 1);
    endtask

    task automatic drain();
        int k;
        req     = '0;
        res_rdy = 1'b1;
        k       = 0;
        tick();
        while (busy && k < 20) begin
            tick();
            k++;
        end
        if (busy) chk("drain_timeout", 0, 1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic run_op(input int id, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] exp_d, input logic exp_ovf);
        int lat;
        set_req(id, a, b);
        lat = 0;
        while (!res_vld && lat < 12) begin
            tick();
            lat++;
            if (lat == 1) chk("gnt_first", gnt, NREQ'(1) << id);
        end
        chk("latency", lat, 3);
        chk("op_data", res_data, exp_d);
        chk("op_ovf", res_ovf, exp_ovf);
        chk("op_id", res_id, id);
        tick();
    endtask

    initial begin
        int w;
        int rr_exp[5] = '{0, 1, 2, 3, 0};
        logic [N-1:0] held;

        // Pin the reference adder against hand-computed values.
        chk("pin_sub", ref_add(32'h00C00000, 32'h80400000), {1'b0, 32'h00800000});
        chk("pin_zero", ref_add(32'h00800000, 32'h80800000), {1'b0, 32'h00000000});
        chk("pin_ovf_pos", ref_add(32'h7FFFFFFF, 32'h00000001), {1'b1, 32'h00000000});
        chk("pin_ovf_neg", ref_add(32'hFFFFFFFF, 32'h80000001), {1'b1, 32'h80000000});

        // Reset state.
        tick();
        tick();
        chk("rst_res_data", res_data, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_res_ovf", res_ovf, 0);
        rst = 1'b1;
        tick();

        // Directed arithmetic.
        run_op(0, ONE + (ONE >> 1), 32'h80400000, 32'h00800000, 1'b0);
        run_op(1, 32'h00800000, 32'h80800000, 32'h00000000, 1'b0);
        run_op(2, 32'h7FFFFFFF, 32'h00000001, 32'h00000000, 1'b1);
        run_op(3, 32'hFFFFFFFF, 32'h80000001, 32'h80000000, 1'b1);

        // Round-robin order with all requesters re-raising after each grant.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_rand(i);
        for (int j = 0; j < 5; j++) begin
            wait_gnt("rr", w);
            chk("rr_order", w, rr_exp[j]);
            tick();
            if (j < 4 && w >= 0) set_rand(w);
        end
        drain();
        set_rand(1);
        wait_gnt("rr_one", w);
        chk("rr_lone1", w, 1);
        tick();
        set_rand(1);
        set_rand(3);
        wait_gnt("rr_skip", w);
        chk("rr_skip_to3", w, 3);
        drain();

        // Backpressure in OUT with another request pending.
        res_rdy = 1'b0;
        set_rand(1);
        set_rand(2);
        wait_vld("bp");
        held = res_data;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_vld", res_vld, 1);
            chk("bp_data", res_data, held);
            chk("bp_gnt", gnt, 0);
            chk("bp_busy", busy, 1);
        end
        res_rdy = 1'b1;
        tick();
        chk("bp_idle", busy, 0);
        tick();
        chk("bp_next_gnt", gnt, 4'b0100);
        drain();

        // Reset in the middle of an operation.
        set_rand(0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_vld", res_vld, 0);
        chk("mid_rst_busy", busy, 0);
        tick();
        tick();
        rst = 1'b1;
        req = '0;
        tick();
        set_req(3, 32'h01000000, 32'h00800000);
        set_rand(0);
        wait_gnt("post_rst", w);
        chk("post_rst_first", w, 0);
        wait_gnt("post_rst3", w);
        chk("post_rst_second", w, 3);
        wait_vld("post_rst3");
        chk("post_rst_id", res_id, 3);
        chk("post_rst_data", res_data, 32'h01800000);
        drain();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && !gnt[i] && $urandom_range(3) == 0) set_rand(i);
                else if (req[i] && $urandom_range(40) == 0) req[i] = 1'b0;
            end
            res_rdy = ($urandom_range(3) != 0);
            if ($urandom_range(400) == 0) rst = 1'b0;
            tick();
            if (!rst) begin
                tick();
                rst = 1'b1;
            end
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
